// File: rtl/adder64_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder64_seq_ctrl
// Function : Round-robin two-requester 64-bit adder built from two passes over
//            a shared 32-bit prefix carry network (low half, then high half).
// Revision : 1.0 - initial release
// ============================================================================
module adder64_seq_ctrl #(
    parameter bit CIN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req0_cin,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic        req1_cin,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_sum,
    output logic        res_cout,
    output logic        res_id,
    output logic [31:0] net_g,
    output logic [31:0] net_p,
    input  logic [31:0] net_go,
    input  logic [31:0] net_po
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        r_last;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic        r_cin;
    logic        r_id;
    logic        r_c32;
    logic        r_cout;
    logic [31:0] r_sum_lo;
    logic [31:0] r_sum_hi;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_pass_cin;
    logic [31:0] w_carry;
    logic [31:0] w_pass_sum;
    logic        w_pass_cout;

    // On a tie the requester that was not served last wins.
    assign w_grant0 = req0_valid & (~req1_valid | r_last);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last);

    // The network returns prefixes over [i:0] with zero carry-in; fold the
    // pass carry-in in here so one network serves both halves.
    assign w_pass_cin  = (r_state == S_HI) ? r_c32 : r_cin;
    assign w_carry     = {net_go[30:0] | (net_po[30:0] & {31{w_pass_cin}}), w_pass_cin};
    assign w_pass_sum  = net_p ^ w_carry;
    assign w_pass_cout = net_go[31] | (net_po[31] & w_pass_cin);

    assign res_sum  = {r_sum_hi, r_sum_lo};
    assign res_cout = r_cout;
    assign res_id   = r_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant0 | w_grant1) w_next = S_LO;
            S_LO:    w_next = S_HI;
            S_HI:    w_next = S_DONE;
            S_DONE:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        net_g      = '0;
        net_p      = '0;
        case (r_state)
            S_IDLE: begin
                req0_ready = w_grant0 & ~rst;
                req1_ready = w_grant1 & ~rst;
            end
            S_LO: begin
                net_g = r_a[31:0] & r_b[31:0];
                net_p = r_a[31:0] ^ r_b[31:0];
            end
            S_HI: begin
                net_g = r_a[63:32] & r_b[63:32];
                net_p = r_a[63:32] ^ r_b[63:32];
            end
            S_DONE:  res_valid = 1'b1;
            default: res_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_id     <= 1'b0;
            r_c32    <= 1'b0;
            r_cout   <= 1'b0;
            r_sum_lo <= '0;
            r_sum_hi <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 | w_grant1) begin
                        r_a    <= w_grant1 ? req1_a : req0_a;
                        r_b    <= w_grant1 ? req1_b : req0_b;
                        r_cin  <= (w_grant1 ? req1_cin : req0_cin) & CIN_EN;
                        r_id   <= w_grant1;
                        r_last <= w_grant1;
                    end
                end
                S_LO: begin
                    r_sum_lo <= w_pass_sum;
                    r_c32    <= w_pass_cout;
                end
                S_HI: begin
                    r_sum_hi <= w_pass_sum;
                    r_cout   <= w_pass_cout;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder64_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder64_seq_ctrl
// Function : Self-checking bench; operation-level reference model plus directed
//            literal cases, with a second instance built without carry-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder64_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0, c0 = 1'b0, c1 = 1'b0, rr = 1'b0;
    logic [63:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

    logic        r0, r1, rv, cout, id;
    logic [63:0] sum;
    logic [31:0] ng, np, go, po;
    logic        x_r0, x_r1, x_rv, x_cout, x_id;
    logic [63:0] x_sum;
    logic [31:0] x_ng, x_np, x_go, x_po;

    int n_chk = 0;
    int n_pass = 0;
    int n_res = 0;

    always #5 clk = ~clk;

    // Reference prefix network: carry generate/propagate over bits [i:0].
    function automatic logic [63:0] net_model(input logic [31:0] g, input logic [31:0] p);
        logic [31:0] gv, pv;
        logic gg, pp;
        gg = 1'b0;
        pp = 1'b1;
        for (int i = 0; i < 32; i++) begin
            gg    = g[i] | (p[i] & gg);
            pp    = pp & p[i];
            gv[i] = gg;
            pv[i] = pp;
        end
        return {gv, pv};
    endfunction

    assign {go, po}     = net_model(ng, np);
    assign {x_go, x_po} = net_model(x_ng, x_np);

    adder64_seq_ctrl #(.CIN_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_cin(c0),
        .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_cin(c1),
        .res_valid(rv), .res_ready(rr), .res_sum(sum), .res_cout(cout), .res_id(id),
        .net_g(ng), .net_p(np), .net_go(go), .net_po(po)
    );

    adder64_seq_ctrl #(.CIN_EN(1'b0)) dut_nc (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(x_r0), .req0_a(a0), .req0_b(b0), .req0_cin(c0),
        .req1_valid(v1), .req1_ready(x_r1), .req1_a(a1), .req1_b(b1), .req1_cin(c1),
        .res_valid(x_rv), .res_ready(rr), .res_sum(x_sum), .res_cout(x_cout), .res_id(x_id),
        .net_g(x_ng), .net_p(x_np), .net_go(x_go), .net_po(x_po)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Operation-level model: which request is in flight and how far along it is.
    int          m_phase = 0;      // 0 idle, 1 low pass, 2 high pass, 3 result held
    logic        m_last = 1'b1;
    logic [63:0] m_a = '0, m_b = '0;
    logic        m_cin = 1'b0, m_id = 1'b0;
    int          m_acc = 0;

    wire m_g0 = !rst && m_phase == 0 && v0 && (!v1 || m_last);
    wire m_g1 = !rst && m_phase == 0 && v1 && (!v0 || !m_last);
    wire [64:0] m_full    = {1'b0, m_a} + {1'b0, m_b} + {64'd0, m_cin};
    wire [64:0] m_full_nc = {1'b0, m_a} + {1'b0, m_b};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_last  <= 1'b1;
        end else begin
            if (m_phase == 0 && (m_g0 || m_g1)) begin
                m_a     <= m_g1 ? a1 : a0;
                m_b     <= m_g1 ? b1 : b0;
                m_cin   <= m_g1 ? c1 : c0;
                m_id    <= m_g1;
                m_last  <= m_g1;
                m_phase <= 1;
                m_acc   <= m_acc + 1;
            end else if (m_phase == 1 || m_phase == 2) begin
                m_phase <= m_phase + 1;
            end else if (m_phase == 3 && rr) begin
                m_phase <= 0;
            end
            if (rv && rr) n_res <= n_res + 1;
        end
    end

    always @(negedge clk) begin
        logic [31:0] eg, ep;
        eg = '0;
        ep = '0;
        if (m_phase == 1) begin eg = m_a[31:0] & m_b[31:0];   ep = m_a[31:0] ^ m_b[31:0];   end
        if (m_phase == 2) begin eg = m_a[63:32] & m_b[63:32]; ep = m_a[63:32] ^ m_b[63:32]; end
        chk("ready0", 64'(r0), 64'(m_g0));
        chk("ready1", 64'(r1), 64'(m_g1));
        chk("x_ready0", 64'(x_r0), 64'(m_g0));
        chk("res_valid", 64'(rv), 64'(m_phase == 3));
        chk("net_g", 64'(ng), 64'(eg));
        chk("net_p", 64'(np), 64'(ep));
        if (m_phase == 3) begin
            chk("res_sum", sum, m_full[63:0]);
            chk("res_cout", 64'(cout), 64'(m_full[64]));
            chk("res_id", 64'(id), 64'(m_id));
            chk("x_res_sum", x_sum, m_full_nc[63:0]);
            chk("x_res_cout", 64'(x_cout), 64'(m_full_nc[64]));
        end
    end

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = '1;
            1: v = '0;
            2: v[63:32] = '0;
            3: v[31:0] = '1;
            default: v = v;
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int who);
        who = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (r0) begin who = 0; break; end
            if (r1) begin who = 1; break; end
        end
        if (who < 0) chk("grant_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int who;
        int ids[4];
        longint tg[4];
        logic [63:0] held;
        int acc, base, guard;
        logic hs0, hs1;

        // Reset: ready must stay low even with a valid request pending.
        v0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready0", 64'(r0), 64'd0);
        chk("rst_sum", sum, 64'd0);
        tick();
        rst = 1'b0;

        // Carry across the half boundary.
        a0 = 64'h0000_0000_FFFF_FFFF; b0 = 64'd1; c0 = 1'b0; rr = 1'b1;
        wait_grant(who);
        chk("t1_who", 64'(who), 64'd0);
        tick(); v0 = 1'b0;
        @(negedge clk);
        chk("t1_net_g", 64'(ng), 64'h0000_0001);
        chk("t1_net_p", 64'(np), 64'hFFFF_FFFE);
        @(negedge clk);
        chk("t1_valid_hi", 64'(rv), 64'd0);
        @(negedge clk);
        chk("t1_valid", 64'(rv), 64'd1);
        chk("t1_sum", sum, 64'h0000_0001_0000_0000);
        chk("t1_cout", 64'(cout), 64'd0);
        chk("t1_id", 64'(id), 64'd0);
        tick();

        // Full-width carry ripple, with and without carry-in honoured.
        a1 = '1; b1 = '0; c1 = 1'b1; v1 = 1'b1;
        wait_grant(who);
        chk("t2_who", 64'(who), 64'd1);
        tick(); v1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_sum", sum, 64'd0);
        chk("t2_cout", 64'(cout), 64'd1);
        chk("t2_id", 64'(id), 64'd1);
        chk("t2_nc_sum", x_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_nc_cout", 64'(x_cout), 64'd0);
        tick();

        // Both requesters hold valid: grants alternate, 4 cycles apart.
        a0 = 64'h1111; b0 = 64'h2222; a1 = 64'h3333; b1 = 64'h4444;
        v0 = 1'b1; v1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(who);
            ids[k] = who;
            tg[k]  = $time;
            tick();
            if (who == 0) begin a0 = rnd64(); b0 = rnd64(); c0 = 1'($urandom_range(0, 1)); end
            else          begin a1 = rnd64(); b1 = rnd64(); c1 = 1'($urandom_range(0, 1)); end
        end
        v0 = 1'b0; v1 = 1'b0;
        for (int k = 0; k < 4; k++) chk("t3_grant_order", 64'(ids[k]), 64'(k % 2));
        for (int k = 1; k < 4; k++) chk("t3_spacing", 64'(tg[k] - tg[k-1]), 64'd40);
        repeat (5) tick();

        // Backpressure: result held, no grants while DONE.
        a0 = rnd64(); b0 = rnd64(); c0 = 1'b1; v0 = 1'b1; rr = 1'b0;
        wait_grant(who);
        tick(); v0 = 1'b0; v1 = 1'b1;
        repeat (3) @(negedge clk);
        held = sum;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_hold_sum", sum, held);
            chk("t4_hold_valid", 64'(rv), 64'd1);
            chk("t4_hold_ready", 64'({r0, r1}), 64'd0);
        end
        tick(); rr = 1'b1;
        @(negedge clk);
        chk("t4_still_done", 64'(rv), 64'd1);
        tick();
        @(negedge clk);
        chk("t4_regrant", 64'(r1), 64'd1);
        tick(); v1 = 1'b0;
        repeat (4) tick();

        // Reset during the high pass discards the operation.
        a0 = rnd64(); b0 = rnd64(); v0 = 1'b1;
        wait_grant(who);
        tick(); v0 = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("t5_valid", 64'(rv), 64'd0);
        chk("t5_net_g", 64'(ng), 64'd0);
        chk("t5_net_p", 64'(np), 64'd0);
        chk("t5_sum", sum, 64'd0);
        chk("t5_cout_id", 64'({cout, id}), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_no_result", 64'(rv), 64'd0);
        end
        tick();
        a0 = rnd64(); b0 = rnd64(); a1 = rnd64(); b1 = rnd64(); v0 = 1'b1; v1 = 1'b1;
        wait_grant(who);
        chk("t5_tie_after_rst", 64'(who), 64'd0);
        tick(); v0 = 1'b0; v1 = 1'b0;
        repeat (5) tick();

        // Random operands and handshake timing.
        acc = 0;
        guard = 0;
        base = n_res;
        while (acc < 4000 && guard < 60000) begin
            guard++;
            rr = ($urandom_range(0, 3) != 0);
            if (!v0 && $urandom_range(0, 2) == 0) begin
                v0 = 1'b1; a0 = rnd64(); c0 = 1'($urandom_range(0, 1));
                b0 = ($urandom_range(0, 3) == 0) ? ~a0 : rnd64();
            end
            if (!v1 && $urandom_range(0, 2) == 0) begin
                v1 = 1'b1; a1 = rnd64(); c1 = 1'($urandom_range(0, 1));
                b1 = ($urandom_range(0, 3) == 0) ? ~a1 : rnd64();
            end
            @(negedge clk);
            hs0 = r0;
            hs1 = r1;
            tick();
            if (hs0) begin acc++; v0 = 1'b0; end
            if (hs1) begin acc++; v1 = 1'b0; end
        end
        chk("rand_accepts", 64'(acc), 64'd4000);
        v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
        repeat (8) tick();
        chk("rand_results", 64'(n_res - base), 64'(acc));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
